// File: rtl/bcd_sevenseg_scan.sv
// Multiplexed common-anode seven-segment driver: scans one digit per refresh
// period, snapshots the BCD/dp inputs once per frame, registered active-low outputs.
module bcd_sevenseg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int PS_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(REFRESH_DIV - 1);
    localparam logic [PS_W-1:0]       PS_ONE   = PS_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [6:0]            SEG_OFF  = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    // Active-low {g,f,e,d,c,b,a}; any non-decimal code shows a lone dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Bit i set when digits i..NUM_DIGITS-1 are all zero (invalid codes are nonzero).
    function automatic logic [NUM_DIGITS-1:0] zeros_above(input logic [4*NUM_DIGITS-1:0] digits);
        logic [NUM_DIGITS-1:0] res;
        logic                  run;
        res = '0;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run    = run & (digits[4*i +: 4] == 4'd0);
            res[i] = run;
        end
        return res;
    endfunction

    logic [PS_W-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick_s;
    logic                    frame_s;
    logic [3:0]              digit_s;
    logic [NUM_DIGITS-1:0]   zeros_s;
    logic                    blank_s;

    // Scan state: prescaler, digit index, frame snapshot and frame pulse.
    always_comb begin
        tick_s       = (presc_q == PS_LAST);
        frame_s      = tick_s && (idx_q == IDX_LAST);
        presc_d      = presc_q;
        idx_d        = idx_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        frame_done_d = 1'b0;
        if (en) begin
            if (tick_s) begin
                presc_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end else begin
                presc_d = presc_q + PS_ONE;
            end
            if (frame_s) begin
                shadow_bcd_d = bcd_in;
                shadow_dp_d  = dp_in;
            end else begin
                shadow_bcd_d = shadow_bcd_q;
                shadow_dp_d  = shadow_dp_q;
            end
            frame_done_d = frame_s;
        end else begin
            frame_done_d = 1'b0;
        end
    end

    // Output decode works on the post-edge index and snapshot so every output moves with idx.
    always_comb begin
        digit_s = shadow_bcd_d[{idx_d, 2'b00} +: 4];
        zeros_s = zeros_above(shadow_bcd_d);
        blank_s = blank_lz && (idx_d != '0) && zeros_s[idx_d];
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        dp_n_d  = 1'b1;
        if (en) begin
            an_d   = ~(AN_ONE << idx_d);
            dp_n_d = ~shadow_dp_d[idx_d];
            if (blank_s) begin
                seg_d = SEG_OFF;
            end else begin
                seg_d = bcd_to_seg(digit_s);
            end
        end else begin
            an_d   = AN_OFF;
            seg_d  = SEG_OFF;
            dp_n_d = 1'b1;
        end
    end

    // State and output registers; reset blanks the display without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Directed bench for bcd_sevenseg_scan (4 digits, 4-cycle refresh); k counts
// enabled rising edges since scanning started from reset state.
module tb_bcd_sevenseg_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    bcd_sevenseg_scan #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp, input logic e_fd);
        check({tag, ".an"},  32'(an),         32'(e_an));
        check({tag, ".seg"}, 32'(seg),        32'(e_seg));
        check({tag, ".dp"},  32'(dp_n),       32'(e_dp));
        check({tag, ".fd"},  32'(frame_done), 32'(e_fd));
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        bcd_in   = 16'h0000;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;

        // Reset, then release with scanning disabled
        cyc(3);
        check_out("rst_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(5);
        check_out("rst_rel_en0", 4'hF, 7'h7F, 1'b1, 1'b0);

        // Scan 1234; first frame shows the zero snapshot
        en     = 1'b1;
        bcd_in = 16'h1234;
        cyc(1);   // k=1
        check_out("k1_first", 4'hE, 7'h40, 1'b1, 1'b0);
        cyc(14);  // k=15
        check_out("k15_d3_old", 4'h7, 7'h40, 1'b1, 1'b0);
        cyc(1);   // k=16
        check_out("k16_frame", 4'hE, 7'h19, 1'b1, 1'b1);
        cyc(1);   // k=17
        check_out("k17_pulse_end", 4'hE, 7'h19, 1'b1, 1'b0);
        cyc(3);   // k=20
        check_out("k20_d1", 4'hD, 7'h30, 1'b1, 1'b0);

        // New value mid-frame must not tear the display
        bcd_in = 16'h5678;
        cyc(4);   // k=24
        check_out("k24_d2_snap", 4'hB, 7'h24, 1'b1, 1'b0);
        cyc(4);   // k=28
        check_out("k28_d3_snap", 4'h7, 7'h79, 1'b1, 1'b0);
        cyc(4);   // k=32
        check_out("k32_frame_new", 4'hE, 7'h00, 1'b1, 1'b1);
        cyc(1);   // k=33
        bcd_in = 16'h00A9;
        dp_in  = 4'b0010;
        cyc(3);   // k=36
        check_out("k36_d1_7", 4'hD, 7'h78, 1'b1, 1'b0);

        // Invalid code dash and decimal point
        cyc(12);  // k=48
        check_out("k48_d0_9", 4'hE, 7'h10, 1'b1, 1'b1);
        cyc(1);   // k=49
        bcd_in = 16'h0070;
        dp_in  = 4'b0000;
        cyc(3);   // k=52
        check_out("k52_d1_dash_dp", 4'hD, 7'h3F, 1'b0, 1'b0);
        cyc(1);   // k=53
        blank_lz = 1'b1;
        cyc(3);   // k=56
        check_out("k56_d2_lzb", 4'hB, 7'h7F, 1'b1, 1'b0);
        cyc(4);   // k=60
        check_out("k60_d3_lzb", 4'h7, 7'h7F, 1'b1, 1'b0);

        // Leading-zero blanking on 0070
        cyc(4);   // k=64
        check_out("k64_d0_never_blank", 4'hE, 7'h40, 1'b1, 1'b1);
        cyc(4);   // k=68
        check_out("k68_d1_7", 4'hD, 7'h78, 1'b1, 1'b0);
        cyc(4);   // k=72
        check_out("k72_d2_blank", 4'hB, 7'h7F, 1'b1, 1'b0);
        cyc(4);   // k=76
        check_out("k76_d3_blank", 4'h7, 7'h7F, 1'b1, 1'b0);
        cyc(1);   // k=77
        blank_lz = 1'b0;
        cyc(11);  // k=88
        check_out("k88_d2_zero", 4'hB, 7'h40, 1'b1, 1'b0);

        // Disable while on digit 2 (prescaler at 1)
        cyc(1);   // k=89
        en = 1'b0;
        cyc(1);
        check_out("dis_first", 4'hF, 7'h7F, 1'b1, 1'b0);
        cyc(9);
        check_out("dis_tenth", 4'hF, 7'h7F, 1'b1, 1'b0);
        en = 1'b1;
        cyc(1);   // prescaler 1->2
        check_out("resume_1", 4'hB, 7'h40, 1'b1, 1'b0);
        cyc(1);   // prescaler 2->3
        check_out("resume_2", 4'hB, 7'h40, 1'b1, 1'b0);
        cyc(1);   // tick -> digit 3
        check_out("resume_3", 4'h7, 7'h40, 1'b1, 1'b0);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check_out("async_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
        cyc(3);
        check_out("rst_held", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(1);
        check_out("post_rst_first", 4'hE, 7'h40, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_sevenseg_scan.md
Name: bcd_sevenseg_scan

Overview:
Time-multiplexed seven-segment display driver. It consumes the packed BCD digits produced by the decade counter chain and drives a common-anode multi-digit display. It scans one digit at a time at a prescaled refresh rate. Inputs are snapshotted once per scan frame so the display never shows a torn value. It supports leading-zero blanking, per-digit decimal points and a dash glyph for invalid BCD codes.

Parameters:
NUM_DIGITS, 4, number of display digits scanned; legal range 1..8.
REFRESH_DIV, 50000, clock cycles each digit stays lit; legal range >= 2.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous active-low reset; rst=0 forces reset state immediately.
en  input  1  scan enable; 0 blanks the display and freezes scanning.
bcd_in  input  4*NUM_DIGITS  packed BCD; digit i = bcd_in[4i+3:4i]; digit 0 is least significant.
dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
blank_lz  input  1  1 = suppress leading zeros; sampled live, not snapshotted.
an  output  NUM_DIGITS  digit enables, active-low, one-hot-low while scanning.
seg  output  7  segments, active-low, seg[6:0] = {g,f,e,d,c,b,a}.
dp_n  output  1  decimal point, active-low.
frame_done  output  1  one-cycle pulse when a new frame starts and the snapshot is reloaded.

Behaviour:
- Reset (rst=0, asynchronous):
  - prescaler=0, digit index idx=0, shadow BCD=0, shadow dp=0.
  - an = all 1s, seg = 7'h7F, dp_n = 1, frame_done = 0.
  - Reset asserted mid-frame takes effect at once, with no clock edge required.
- Prescaler, when en=1:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick is asserted while the count equals REFRESH_DIV-1.
- Digit index: on a tick edge, idx advances by 1 and wraps from NUM_DIGITS-1 to 0.
- Frame boundary (tick edge with idx=NUM_DIGITS-1):
  - Shadow registers load bcd_in and dp_in.
  - frame_done = 1 for exactly that following cycle.
  - bcd_in changes at any other time have no visible effect until the next frame boundary.
- Outputs are registered. On every rising edge with en=1, an, seg and dp_n load the decode of the post-edge idx and shadow.
  - All outputs change on the same edge as idx, with no glitch cycle between digits.
  - The first edge after reset release with en=1 lights digit 0 showing shadow 0, so seg=7'h40.
- an: bit idx = 0, all other bits = 1.
- Decode, BCD to seg (hex):
  - 0 -> 40, 1 -> 79, 2 -> 24, 3 -> 30, 4 -> 19
  - 5 -> 12, 6 -> 02, 7 -> 78, 8 -> 00, 9 -> 10
  - Codes 10..15 -> 3F (dash, segment g only).
- Leading-zero blanking, when blank_lz=1:
  - Digit i > 0 shows seg=7F if shadow digits i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - an still selects the blanked digit.
  - dp_n still follows the shadow dp.
  - Invalid codes count as nonzero.
- dp_n = ~shadow_dp[idx].
- en=0:
  - Next edge: an = all 1s, seg = 7F, dp_n = 1.
  - prescaler, idx and shadow hold, and frame_done = 0.
  - Re-asserting en resumes the same digit with the held prescaler count.
- A frame therefore lasts NUM_DIGITS*REFRESH_DIV enabled cycles.

Test Plan:
(All cases use NUM_DIGITS=4, REFRESH_DIV=4.)
1. Hold rst=0, then release with en=0 -> an=1111, seg=7F, dp_n=1, frame_done=0 stay stable indefinitely.
2. en=1, bcd_in=16'h1234, dp_in=0000.
   - The first frame shows 0 on digit 0 (seg=40, an=1110).
   - After 16 cycles frame_done pulses once.
   - Then the display cycles an=1110/seg=19, an=1101/seg=30, an=1011/seg=24, an=0111/seg=79, each held 4 cycles.
3. blank_lz=1, bcd_in=16'h0070 after a snapshot.
   - Digits 3 and 2: seg=7F.
   - Digit 1: seg=78.
   - Digit 0: seg=40.
   - With blank_lz=0, digits 3 and 2 show seg=40.
4. bcd_in=16'h00A9, dp_in=0010.
   - Digit 1: seg=3F, dp_n=0.
   - Digit 0: seg=10, dp_n=1.
5. Change bcd_in from 16'h1234 to 16'h5678 while idx=1.
   - Digits 1..3 still show 3, 2, 1 in this frame.
   - New values appear only after frame_done.
6. Deassert en for 10 cycles while idx=2.
   - Outputs are blanked; idx and prescaler hold.
   - On re-enable, digit 2 resumes.
   - Pulsing rst=0 mid-digit forces an=1111, seg=7F without a clock edge.
